async_fifo_top: RTL and testbench
=================================

// Module: async_fifo_top
// PURPOSE
// - Synchronous FIFO buffer. Write and read sides share one clock; both pointers live in the wclk domain.
// - Sits between a streaming producer (winc/wdata) and a consumer (rinc/rdata/rvalid).
// - Gives full/empty back-pressure and a registered read-data valid strobe.
// PARAMETERS
// - DATA_W   16  width of wdata/rdata
// - ADDR_W    4  address bits; DEPTH = 2**ADDR_W = 16 entries
// PORTS
// - wclk    in   1        single clock for both sides; all logic on posedge wclk
// - wrst_n  in   1        reset for the whole block; synchronous, active-low
// - wdata   in   DATA_W   write data, sampled on an accepted write
// - winc    in   1        write request
// - rinc    in   1        read request
// - wfull   out  1        FIFO holds DEPTH entries
// - rempty  out  1        FIFO holds 0 entries
// - rdata   out  DATA_W   read data, registered
// - rvalid  out  1        rdata carries a newly read word this cycle
// BEHAVIOUR
// - Reset (wrst_n=0 at a posedge):
//   - wptr, rptr <= 0; rdata <= 0; rvalid <= 0.
//   - Resulting state: rempty=1, wfull=0.
//   - Memory contents are not cleared.
// - Pointers are ADDR_W+1 bit binary counters. Bits [ADDR_W-1:0] address the memory; the MSB is the wrap bit.
// - Flags are decoded combinationally from the registered pointers only:
//   - rempty = (wptr == rptr)
//   - wfull  = (wptr[ADDR_W] != rptr[ADDR_W]) && (wptr[ADDR_W-1:0] == rptr[ADDR_W-1:0])
// - Write accepted when winc && !wfull: mem[wptr] <= wdata; wptr <= wptr+1.
// - Read accepted when rinc && !rempty: rdata <= mem[rptr]; rptr <= rptr+1; rvalid <= 1.
//   - Otherwise rvalid <= 0 and rdata holds its value.
// - Latency:
//   - A word written at edge N can be read at edge N+1 at the earliest.
//   - That word appears on rdata, with rvalid=1, after edge N+1.
// - Flags update in the cycle after the pointer change; there is no extra synchronizer latency.
// - Simultaneous winc and rinc:
//   - Each side is qualified independently, using the flags before the edge.
//   - When empty: only the write is accepted.
//   - When full: only the read is accepted. The write is dropped even though a slot frees at this edge.
// - Overflow: winc while wfull is ignored. No pointer or memory change; no error output.
// - Underflow: rinc while rempty is ignored. rvalid=0; rdata holds.
// - Wrap-around: pointers roll over 2**(ADDR_W+1) -> 0 naturally, and data order is preserved across the wrap.
// - Reset mid-operation: all stored words are discarded. The first read after reset returns the first write after reset.
// CONFIGURATION
// - FIFO_LEVEL_EN defined:
//   - Adds output `level [ADDR_W:0]` = wptr - rptr (modulo 2**(ADDR_W+1)), range 0..DEPTH.
//   - level is 0 during and after reset.
// - FIFO_LEVEL_EN undefined: there is no level port, and the rest of the behaviour is identical.
// TESTING
// - Reset, then winc=rinc=1 held constantly, with wdata=0,1,2,... one per cycle:
//   - Expected: rvalid rises 1 cycle after the first write; rdata=0,1,2,... in order.
//   - No gaps; wfull never asserts; rempty toggles only at start-up.
// - Write 16 words (0..15) with rinc=0:
//   - Expected: wfull=1 after the 16th.
//   - A 17th write of 0xFFFF is ignored.
//   - 16 reads then return 0..15; rempty=1 after the last read.
// - rinc=1 on an empty FIFO after reset: rvalid stays 0, rdata stays 0, rptr unchanged.
// - Full FIFO with winc=rinc=1 for one cycle:
//   - Expected: the read returns the oldest word and the write is dropped.
//   - Next cycle: wfull=0, level=15.
// - Wrap-around: 40 words through, with bursts of 10 writes then 10 reads.
//   - Expected: in-order data across both pointer wraps.
// - Assert wrst_n=0 for 1 cycle with 5 words stored:
//   - Expected: rempty=1, rvalid=0, level=0 (when FIFO_LEVEL_EN).
//   - The next write/read pair returns the new word.

Source files
------------

// File: rtl/async_fifo_if.sv
// Producer/consumer handshake bundle for async_fifo_top.
// The optional level signal is present only when FIFO_LEVEL_EN is defined.
interface async_fifo_if #(
   parameter int DATA_W = 16,
   parameter int ADDR_W = 4
);
   logic [DATA_W-1:0] wdata;
   logic              winc;
   logic              rinc;
   logic              wfull;
   logic              rempty;
   logic [DATA_W-1:0] rdata;
   logic              rvalid;
`ifdef FIFO_LEVEL_EN
   logic [ADDR_W:0]   level;
`endif

   modport master (
      output wdata, winc, rinc,
`ifdef FIFO_LEVEL_EN
      input  level,
`endif
      input  wfull, rempty, rdata, rvalid
   );

   modport slave (
      input  wdata, winc, rinc,
`ifdef FIFO_LEVEL_EN
      output level,
`endif
      output wfull, rempty, rdata, rvalid
   );
endinterface

// File: rtl/async_fifo_top.sv
// Single-clock FIFO: binary pointers with a wrap bit, registered read data and valid strobe.
// Define FIFO_LEVEL_EN to drive the occupancy output level on the interface.
module async_fifo_top #(
   parameter int DATA_W = 16,
   parameter int ADDR_W = 4
) (
   input  logic        wclk,
   input  logic        wrst_n,
   async_fifo_if.slave bus
);
   localparam int DEPTH = 2 ** ADDR_W;

   logic [DATA_W-1:0] r_mem [DEPTH];
   logic [ADDR_W:0]   r_wptr;
   logic [ADDR_W:0]   r_rptr;
   logic [DATA_W-1:0] r_rdata;
   logic              r_rvalid;

   logic w_full;
   logic w_empty;
   logic w_wr_en;
   logic w_rd_en;

   assign w_empty = (r_wptr == r_rptr);
   assign w_full  = (r_wptr[ADDR_W] != r_rptr[ADDR_W]) &&
                    (r_wptr[ADDR_W-1:0] == r_rptr[ADDR_W-1:0]);

   // Both sides qualify on the pre-edge flags, so a write into a full FIFO is
   // dropped even when a read frees a slot on the same edge.
   assign w_wr_en = wrst_n && bus.winc && !w_full;
   assign w_rd_en = bus.rinc && !w_empty;

   always_ff @(posedge wclk) begin
      if (w_wr_en) begin
         r_mem[r_wptr[ADDR_W-1:0]] <= bus.wdata;
      end
   end

   always_ff @(posedge wclk) begin
      if (!wrst_n) begin
         r_wptr   <= '0;
         r_rptr   <= '0;
         r_rdata  <= '0;
         r_rvalid <= 1'b0;
      end else begin
         if (w_wr_en) begin
            r_wptr <= r_wptr + 1'b1;
         end
         if (w_rd_en) begin
            r_rdata <= r_mem[r_rptr[ADDR_W-1:0]];
            r_rptr  <= r_rptr + 1'b1;
         end
         r_rvalid <= w_rd_en;
      end
   end

   assign bus.wfull  = w_full;
   assign bus.rempty = w_empty;
   assign bus.rdata  = r_rdata;
   assign bus.rvalid = r_rvalid;
`ifdef FIFO_LEVEL_EN
   assign bus.level  = r_wptr - r_rptr;
`endif
endmodule

// File: tb/tb_async_fifo_top.sv
// Directed self-checking bench for async_fifo_top; inputs change 1 ns after each
// rising edge and outputs are sampled there as well.
module tb_async_fifo_top;
   localparam int DATA_W = 16;
   localparam int ADDR_W = 4;

   logic wclk = 1'b0;
   logic wrst_n;
   int   checks = 0;
   int   failures = 0;

   async_fifo_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

   async_fifo_top #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
      .wclk   (wclk),
      .wrst_n (wrst_n),
      .bus    (bus)
   );

   always #5 wclk = ~wclk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s observed=0x%0h expected=0x%0h at %0t", tag, obs, exp, $time);
      end else begin
         $display("ok   %s = 0x%0h", tag, obs);
      end
   endtask

   task automatic tick();
      @(posedge wclk);
      #1;
   endtask

   task automatic chk_level(input string tag, input int exp);
`ifdef FIFO_LEVEL_EN
      chk(tag, 32'(bus.level), 32'(exp));
`endif
   endtask

   initial begin
      wrst_n    = 1'b0;
      bus.winc  = 1'b0;
      bus.rinc  = 1'b0;
      bus.wdata = '0;
      tick();
      tick();
      chk("rst_rempty", 32'(bus.rempty), 32'd1);
      chk("rst_wfull",  32'(bus.wfull),  32'd0);
      chk("rst_rvalid", 32'(bus.rvalid), 32'd0);
      chk("rst_rdata",  32'(bus.rdata),  32'd0);
      chk_level("rst_level", 0);
      wrst_n = 1'b1;
      tick();

      // Underflow right after reset
      bus.rinc = 1'b1;
      tick();
      chk("uflow_rvalid", 32'(bus.rvalid), 32'd0);
      chk("uflow_rdata",  32'(bus.rdata),  32'd0);
      chk("uflow_rempty", 32'(bus.rempty), 32'd1);

      // Continuous streaming with winc=rinc=1
      bus.winc = 1'b1;
      for (int i = 0; i < 20; i++) begin
         bus.wdata = 16'(i);
         tick();
         if (i == 0) begin
            chk("strm_first_rvalid", 32'(bus.rvalid), 32'd0);
            chk("strm_first_rempty", 32'(bus.rempty), 32'd0);
         end else begin
            chk($sformatf("strm_rvalid_%0d", i), 32'(bus.rvalid), 32'd1);
            chk($sformatf("strm_rdata_%0d", i),  32'(bus.rdata),  32'(i - 1));
            chk($sformatf("strm_wfull_%0d", i),  32'(bus.wfull),  32'd0);
         end
      end
      bus.winc = 1'b0;
      tick();
      chk("strm_last_rdata",  32'(bus.rdata),  32'd19);
      chk("strm_last_rvalid", 32'(bus.rvalid), 32'd1);
      bus.rinc = 1'b0;
      tick();
      chk("strm_end_rempty", 32'(bus.rempty), 32'd1);
      chk("strm_end_rvalid", 32'(bus.rvalid), 32'd0);
      chk("strm_end_hold",   32'(bus.rdata),  32'd19);

      // Fill to full, then one overflow attempt
      bus.winc = 1'b1;
      for (int i = 0; i < 16; i++) begin
         bus.wdata = 16'(i);
         tick();
         if (i == 14) chk("fill_wfull_15", 32'(bus.wfull), 32'd0);
      end
      chk("fill_wfull_16",  32'(bus.wfull),  32'd1);
      chk("fill_rempty_16", 32'(bus.rempty), 32'd0);
      chk_level("fill_level", 16);
      bus.wdata = 16'hFFFF;
      tick();
      chk("oflow_wfull", 32'(bus.wfull), 32'd1);
      chk_level("oflow_level", 16);

      // Full with simultaneous read and write: read wins, write dropped
      bus.wdata = 16'hAAAA;
      bus.rinc  = 1'b1;
      tick();
      bus.winc = 1'b0;
      chk("fullrw_rdata",  32'(bus.rdata),  32'd0);
      chk("fullrw_rvalid", 32'(bus.rvalid), 32'd1);
      chk("fullrw_wfull",  32'(bus.wfull),  32'd0);
      chk_level("fullrw_level", 15);
      for (int i = 1; i < 16; i++) begin
         tick();
         chk($sformatf("drain_rdata_%0d", i), 32'(bus.rdata), 32'(i));
      end
      chk("drain_rempty", 32'(bus.rempty), 32'd1);
      tick();
      chk("drain_extra_rvalid", 32'(bus.rvalid), 32'd0);
      chk("drain_extra_rdata",  32'(bus.rdata),  32'd15);
      bus.rinc = 1'b0;

      // Wrap-around: bursts of 10 writes then 10 reads, 40 words
      for (int b = 0; b < 4; b++) begin
         bus.winc = 1'b1;
         for (int i = 0; i < 10; i++) begin
            bus.wdata = 16'(16'h0100 + b * 10 + i);
            tick();
         end
         bus.winc = 1'b0;
         bus.rinc = 1'b1;
         for (int i = 0; i < 10; i++) begin
            tick();
            chk($sformatf("wrap_rdata_%0d", b * 10 + i), 32'(bus.rdata), 32'(16'h0100 + b * 10 + i));
         end
         bus.rinc = 1'b0;
         chk($sformatf("wrap_rempty_b%0d", b), 32'(bus.rempty), 32'd1);
      end

      // Reset with 5 words stored
      bus.winc = 1'b1;
      for (int i = 0; i < 5; i++) begin
         bus.wdata = 16'(16'h0050 + i);
         tick();
      end
      bus.winc = 1'b0;
      bus.rinc = 1'b1;
      tick();
      chk("prerst_rdata", 32'(bus.rdata), 32'h50);
      wrst_n = 1'b0;
      tick();
      wrst_n   = 1'b1;
      bus.rinc = 1'b0;
      chk("midrst_rempty", 32'(bus.rempty), 32'd1);
      chk("midrst_rvalid", 32'(bus.rvalid), 32'd0);
      chk("midrst_wfull",  32'(bus.wfull),  32'd0);
      chk("midrst_rdata",  32'(bus.rdata),  32'd0);
      chk_level("midrst_level", 0);
      bus.winc  = 1'b1;
      bus.wdata = 16'hBEEF;
      tick();
      bus.winc = 1'b0;
      bus.rinc = 1'b1;
      tick();
      bus.rinc = 1'b0;
      chk("postrst_rdata",  32'(bus.rdata),  32'hBEEF);
      chk("postrst_rvalid", 32'(bus.rvalid), 32'd1);
      chk("postrst_rempty", 32'(bus.rempty), 32'd1);
      tick();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
